// File: rtl/cartram_upload.sv
// Upload reader for cartridge battery RAM. It answers HPS ioctl read strobes for the save index
// by fetching one byte through the cart RAM arbiter.
module cartram_upload #(
  parameter logic [7:0] SAVE_INDEX = 8'd2,
  parameter int         AW         = 13,
  parameter int         RD_LATENCY = 1
) (
  input  logic          CLK_SYS,
  input  logic          RESET,
  input  logic          IOCTL_UPLOAD,
  input  logic [7:0]    IOCTL_INDEX,
  input  logic          IOCTL_RD,
  input  logic [24:0]   IOCTL_ADDR,
  output logic [7:0]    IOCTL_DIN,
  output logic          IOCTL_WAIT,
  output logic          UPLOAD_ACTIVE,
  output logic          RAM_REQ,
  input  logic          RAM_GNT,
  output logic [AW-1:0] RAM_ADDR,
  output logic          RAM_RE,
  input  logic [7:0]    RAM_DATA
);

  // state | meaning
  // IDLE  | waiting for a read strobe
  // REQ   | RAM port requested, waiting for grant
  // READ  | single-cycle RAM read enable
  // LAT   | waiting out the remaining RAM read latency
  // CAPT  | RAM_DATA (or 0xFF for out-of-range) registered into IOCTL_DIN
  typedef enum logic [2:0] {IDLE, REQ, READ, LAT, CAPT} state_t;

  localparam logic [1:0] LAT_INIT = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

  state_t     state;
  logic [1:0] lat_cnt;
  logic       oor;
  logic       active_cond;
  logic       out_of_range;

  assign active_cond  = IOCTL_UPLOAD && (IOCTL_INDEX == SAVE_INDEX);
  assign out_of_range = |IOCTL_ADDR[24:AW];

  always_ff @(posedge CLK_SYS or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      lat_cnt       <= 2'd0;
      oor           <= 1'b0;
      IOCTL_DIN     <= 8'h00;
      IOCTL_WAIT    <= 1'b0;
      UPLOAD_ACTIVE <= 1'b0;
      RAM_REQ       <= 1'b0;
      RAM_ADDR      <= '0;
      RAM_RE        <= 1'b0;
    end else begin
      UPLOAD_ACTIVE <= active_cond;
      RAM_RE        <= 1'b0;
      // Losing the upload session abandons the read; any byte still in the RAM pipe is dropped.
      if (state != IDLE && !active_cond) begin
        state      <= IDLE;
        oor        <= 1'b0;
        IOCTL_WAIT <= 1'b0;
        RAM_REQ    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (IOCTL_RD && UPLOAD_ACTIVE) begin
              IOCTL_WAIT <= 1'b1;
              if (out_of_range) begin
                oor   <= 1'b1;
                state <= CAPT;
              end else begin
                oor      <= 1'b0;
                RAM_REQ  <= 1'b1;
                RAM_ADDR <= IOCTL_ADDR[AW-1:0];
                state    <= REQ;
              end
            end
          end
          REQ: begin
            if (RAM_GNT) begin
              RAM_RE <= 1'b1;
              state  <= READ;
            end
          end
          READ: begin
            if (RD_LATENCY > 1) begin
              lat_cnt <= LAT_INIT;
              state   <= LAT;
            end else begin
              state <= CAPT;
            end
          end
          LAT: begin
            if (lat_cnt == 2'd0) state <= CAPT;
            else                 lat_cnt <= lat_cnt - 2'd1;
          end
          CAPT: begin
            IOCTL_DIN  <= oor ? 8'hFF : RAM_DATA;
            IOCTL_WAIT <= 1'b0;
            RAM_REQ    <= 1'b0;
            oor        <= 1'b0;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/cartram_upload.md
Name: cartram_upload

Overview:
- HPS-side reader for cartridge battery RAM; the upload counterpart of the ROM/RAM download path.
- Answers ioctl upload read requests for the save index by fetching bytes from cart RAM and presenting them on IOCTL_DIN.
- Sits between hps_io and the cart RAM arbiter in the SCV top level.
- Asserts an active flag so the system can pause CPU access to the RAM while a dump is in progress.

Parameters:
- SAVE_INDEX, 8'd2, IOCTL_INDEX value that selects this block.
- AW, 13, cart RAM address width; RAM size is 2**AW bytes.
- RD_LATENCY, 1, cycles from RAM_RE to valid RAM_DATA (1..3).

Ports:
- CLK_SYS  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- IOCTL_UPLOAD  in  1  HPS upload session active.
- IOCTL_INDEX  in  8  upload target index.
- IOCTL_RD  in  1  one-cycle read strobe for IOCTL_ADDR.
- IOCTL_ADDR  in  25  byte address requested.
- IOCTL_DIN  out  8  returned byte.
- IOCTL_WAIT  out  1  stall to HPS; IOCTL_DIN is not valid while high.
- UPLOAD_ACTIVE  out  1  IOCTL_UPLOAD high and IOCTL_INDEX == SAVE_INDEX (registered).
- RAM_REQ  out  1  request for the cart RAM port.
- RAM_GNT  in  1  arbiter grant; may stay high.
- RAM_ADDR  out  AW  RAM byte address.
- RAM_RE  out  1  one-cycle read enable.
- RAM_DATA  in  8  RAM read data, valid RD_LATENCY cycles after RAM_RE.

Behaviour:
- Reset values: IOCTL_DIN=8'h00, IOCTL_WAIT=0, UPLOAD_ACTIVE=0, RAM_REQ=0, RAM_ADDR=0, RAM_RE=0, FSM=IDLE.
- UPLOAD_ACTIVE is registered: it goes high (or low) one cycle after its condition changes.
- FSM states:
  - IDLE: waits for a read strobe.
  - REQ: RAM_REQ=1 and IOCTL_WAIT=1; waits for RAM_GNT.
  - READ: RAM_RE=1 for exactly one cycle, RAM_ADDR=latched address.
  - LAT: counts RD_LATENCY-1 cycles.
  - CAPT: registers RAM_DATA into IOCTL_DIN.
- A strobe is IOCTL_RD sampled high in IDLE while UPLOAD_ACTIVE=1; IOCTL_ADDR[AW-1:0] is latched at that edge.
- Handshake timing:
  - Cycle after the strobe: IOCTL_WAIT=1, RAM_REQ=1.
  - RAM_GNT sampled high in REQ → READ on the next cycle.
  - RAM_DATA sampled in the cycle RD_LATENCY after READ → IOCTL_DIN updated.
  - Next cycle: IOCTL_WAIT=0, RAM_REQ=0, FSM=IDLE.
- Latency with RAM_GNT held high: IOCTL_WAIT high for 2+RD_LATENCY cycles; IOCTL_DIN valid on the first cycle WAIT is low.
- Out-of-range address (IOCTL_ADDR >= 2**AW):
  - No RAM_REQ or RAM_RE.
  - IOCTL_WAIT high for exactly 1 cycle, then IOCTL_DIN=8'hFF.
- IOCTL_RD while FSM != IDLE: ignored. No queueing; the in-flight read completes unchanged.
- IOCTL_RD with UPLOAD_ACTIVE=0 (wrong index or no upload): ignored, no output change.
- IOCTL_UPLOAD falls mid-operation:
  - FSM returns to IDLE the next cycle; IOCTL_WAIT=0, RAM_REQ=0, RAM_RE=0.
  - IOCTL_DIN keeps its last value.
  - Any RAM_DATA still in flight is discarded.
- RAM_GNT low indefinitely: stay in REQ with WAIT high; no timeout.
- RAM_GNT dropping after READ does not abort the capture.
- RESET asserted mid-operation: all outputs return to reset values immediately (asynchronous).
- IOCTL_DIN changes only in CAPT, on the out-of-range path, or on reset.

Test Plan:
- Reset and idle:
  - Assert RESET mid-REQ → WAIT, REQ, RE drop at once, IOCTL_DIN=00.
  - After release, IOCTL_RD with IOCTL_UPLOAD=0 → no RAM_REQ, WAIT stays 0.
- Basic read:
  - Preload RAM[0x0123]=8'h5A, RAM_GNT=1, RD_LATENCY=1, UPLOAD=1, INDEX=2; RD with ADDR=0x0123.
  - → WAIT high 3 cycles, RAM_RE one pulse with RAM_ADDR=0x0123, then IOCTL_DIN=5A with WAIT=0.
- Arbitration stall:
  - Hold RAM_GNT=0 for 10 cycles after RD → WAIT and REQ stay high, no RE.
  - Raise GNT → RE next cycle, byte delivered 2 cycles later.
- Out-of-range:
  - RD with ADDR=0x2000 (AW=13) → 1 WAIT cycle, DIN=FF, no RAM_REQ.
- Abort and overlap:
  - RD, then drop IOCTL_UPLOAD in LAT → IDLE next cycle, DIN unchanged.
  - Second RD while WAIT high → ignored; only one RE pulse.
- Full sweep:
  - Sequential RD of addresses 0..8191 over a RAM holding addr^8'hA5 → every returned byte matches.
  - UPLOAD_ACTIVE high for the whole sweep.
